btn_event_ctrl: RTL
===================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of raw button inputs, range 2..8.
REQ-002 Parameter TICK_DIV, default 1000: clk cycles per debounce sample tick, minimum 2.
REQ-003 Parameter STABLE_TICKS, default 100: consecutive differing ticks required to accept a level change, minimum 2.
REQ-004 Parameter FIFO_DEPTH, default 4: event queue depth, power of two.
REQ-005 clk  in  1  sole clock; all state changes on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 btn_in  in  N_BTN  raw asynchronous button levels.
REQ-008 btn_level  out  N_BTN  debounced levels.
REQ-009 evt_valid  out  1  event queue non-empty.
REQ-010 evt_ready  in  1  consumer accepts head event.
REQ-011 evt_id  out  clog2(N_BTN)  button index of head event.
REQ-012 evt_press  out  1  1 = press (0->1), 0 = release (1->0).
REQ-013 overflow  out  1  sticky flag: an event was lost.
REQ-014 clr_overflow  in  1  clears overflow.

Function
REQ-015 Each btn_in bit SHALL pass through a 2-flop synchronizer before use.
REQ-016 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert the internal tick for the one cycle when it equals TICK_DIV-1.
REQ-017 Per button: if sync == btn_level, the stability counter SHALL clear to 0 on every cycle, tick or not.
REQ-018 Per button: if sync != btn_level on a tick, the counter SHALL increment; on the tick where it equals STABLE_TICKS-1, btn_level SHALL toggle and the counter SHALL clear.
REQ-019 A btn_level toggle SHALL set that button's pending flag and record its direction in the same edge.
REQ-020 If a toggle occurs while pending is already set and not granted that cycle, direction SHALL be overwritten and overflow SHALL set.
REQ-021 Arbiter: each cycle with any pending and the FIFO not full, grant the first pending index at or after rr_ptr (wrapping); push {id, dir}; clear that pending flag; set rr_ptr = grant+1 mod N_BTN.
REQ-022 Same-cycle grant and new toggle on one button: the new toggle's pending set wins, and overflow SHALL NOT set.
REQ-023 FIFO full: no grant; pending flags hold; no loss.
REQ-024 FIFO is show-ahead: evt_id/evt_press reflect head whenever evt_valid=1; pop on evt_valid && evt_ready.
REQ-025 Push and pop in one cycle SHALL both occur when not full; full status uses the registered count, so a pop does not admit a same-cycle push.
REQ-026 Latency: btn_level toggles at edge E; pending visible after E; FIFO write at E+1; evt_valid high after E+1 if uncontended.
REQ-027 Overflow set and clr_overflow in one cycle: set wins.

Reset
REQ-028 On rst, all the following SHALL be 0 at the next edge: synchronizers, prescaler, stability counters, btn_level, pending, rr_ptr, FIFO pointers/count, overflow; evt_valid=0.
REQ-029 rst mid-operation SHALL discard queued and pending events; no event for the reset-induced level clear.

Structure
REQ-030 Package btn_event_pkg SHALL hold parameter defaults, the event record {id, press}, and its width constant.
REQ-031 FIFO SHALL be sub-module btn_evt_fifo (parameterised depth/width, sync reset, show-ahead); everything else stays in btn_event_ctrl.

Verification (bench: N_BTN=4, TICK_DIV=4, STABLE_TICKS=3)
REQ-032 btn_in[1] 0->1 held -> btn_level[1]=1 after 3 ticks (about 12 cycles plus 2 sync); one event id=1 press=1; evt_valid 1 cycle after level change.
REQ-033 btn_in[2] glitch high for 8 cycles (2 ticks), then low -> no level change, no event.
REQ-034 btn_in[0] and btn_in[3] rise together, rr_ptr=1 -> events in order id=3 then id=0 on consecutive cycles; rr_ptr ends at 1.
REQ-035 evt_ready=0 with 6 events generated -> 4 queued, 2 held pending; overflow stays 0; releasing ready drains all 6 in order.
REQ-036 Button toggles twice while its pending is blocked by a full FIFO -> overflow=1, last direction kept; clr_overflow -> 0.
REQ-037 rst asserted with 2 queued events and btn_level=4'b0011 -> next cycle evt_valid=0, btn_level=0, no spurious events afterward.

Source files
------------

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event controller.
// Holds the parameter defaults, the queued event record {id, press} and the
// record width used to size the event FIFO.
package btn_event_pkg;

    localparam int N_BTN_DEF        = 4;
    localparam int TICK_DIV_DEF     = 1000;
    localparam int STABLE_TICKS_DEF = 100;
    localparam int FIFO_DEPTH_DEF   = 4;

    // The id field is sized for the largest supported button count (8).
    localparam int EVT_ID_W = 3;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                press;
    } btn_evt_t;

    localparam int EVT_W = $bits(btn_evt_t);

endpackage

// File: rtl/btn_evt_fifo.sv
// Show-ahead synchronous FIFO for button events.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write request and data (ignored while full)
//   pop        - read request (ignored while empty)
//   dout       - head entry, meaningful whenever valid = 1
//   valid      - FIFO non-empty
//   full       - FIFO full, from the registered occupancy count
module btn_evt_fifo
    import btn_event_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status and handshake qualification; a same-cycle pop never frees room for a push
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        valid     = (count_r != '0);
        do_push_s = push & ~full;
        do_pop_s  = pop & valid;
        dout      = mem_r[rd_ptr_r];
    end

    // Entry storage; contents are only observed while valid, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping (power-of-two depth wraps naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button debouncer and press/release event queue.
// Raw buttons are synchronised, debounced on a prescaled tick, and each
// accepted level change becomes a pending event; a round-robin arbiter moves
// pending events into a show-ahead FIFO read by the consumer.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   btn_in[N_BTN]          - raw asynchronous button levels
//   btn_level[N_BTN]       - debounced levels
//   evt_valid / evt_ready  - event queue handshake (pop on valid && ready)
//   evt_id, evt_press      - head event: button index, 1 = press / 0 = release
//   overflow, clr_overflow - sticky lost-event flag and its clear
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int N_BTN        = N_BTN_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_in,
    output logic [N_BTN-1:0]         btn_level,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int IDX_W = $clog2(N_BTN);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS);

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] pending_r;
    logic [N_BTN-1:0] pdir_r;
    logic [PRE_W-1:0] presc_r;
    logic [CNT_W-1:0] stab_cnt_r [N_BTN];
    logic [IDX_W-1:0] rr_ptr_r;
    logic             overflow_r;

    logic             tick_s;
    logic [N_BTN-1:0] diff_s;
    logic [N_BTN-1:0] toggle_s;
    logic [N_BTN-1:0] grant_vec_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_valid_s;
    logic             ovf_set_s;
    logic             fifo_full_s;
    logic             fifo_valid_s;
    btn_evt_t         push_evt_s;
    btn_evt_t         head_evt_s;

    // Sample tick and per-button debounce decision
    always_comb begin
        tick_s = (presc_r == PRE_W'(TICK_DIV - 1));
        diff_s = sync2_r ^ level_r;
        for (int i = 0; i < N_BTN; i++) begin
            toggle_s[i] = tick_s & diff_s[i] & (stab_cnt_r[i] == CNT_W'(STABLE_TICKS - 1));
        end
    end

    // Round-robin grant: lowest pending index at or after rr_ptr, else lowest overall
    always_comb begin
        grant_idx_s = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            grant_idx_s = pending_r[i] ? IDX_W'(i) : grant_idx_s;
        end
        for (int i = N_BTN - 1; i >= 0; i--) begin
            grant_idx_s = (pending_r[i] && (IDX_W'(i) >= rr_ptr_r)) ? IDX_W'(i) : grant_idx_s;
        end
        grant_valid_s = (|pending_r) & ~fifo_full_s;
        grant_vec_s   = '0;
        if (grant_valid_s) begin
            grant_vec_s[grant_idx_s] = 1'b1;
        end else begin
            grant_vec_s = '0;
        end
        push_evt_s.id    = EVT_ID_W'(grant_idx_s);
        push_evt_s.press = pdir_r[grant_idx_s];
        // A toggle on a button whose pending event is leaving this cycle is not a loss
        ovf_set_s = |(toggle_s & pending_r & ~grant_vec_s);
    end

    // Prescaler producing one tick every TICK_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Synchronisers, stability counters and debounced levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            level_r <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stab_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            level_r <= level_r ^ toggle_s;
            for (int i = 0; i < N_BTN; i++) begin
                if (!diff_s[i] || toggle_s[i]) begin
                    stab_cnt_r[i] <= '0;
                end else if (tick_s) begin
                    stab_cnt_r[i] <= stab_cnt_r[i] + CNT_W'(1);
                end else begin
                    stab_cnt_r[i] <= stab_cnt_r[i];
                end
            end
        end
    end

    // Pending flags and directions; a new toggle outranks a same-cycle grant
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
            pdir_r    <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (toggle_s[i]) begin
                    pending_r[i] <= 1'b1;
                    pdir_r[i]    <= ~level_r[i];
                end else if (grant_vec_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Round-robin pointer advances past each granted index
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (grant_valid_s) begin
            rr_ptr_r <= (grant_idx_s == IDX_W'(N_BTN - 1)) ? '0 : grant_idx_s + IDX_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sticky overflow flag; a new loss outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (clr_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    btn_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant_valid_s),
        .din   (push_evt_s),
        .pop   (evt_ready),
        .dout  (head_evt_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s)
    );

    assign btn_level = level_r;
    assign evt_valid = fifo_valid_s;
    assign evt_id    = IDX_W'(head_evt_s.id);
    assign evt_press = head_evt_s.press;
    assign overflow  = overflow_r;

endmodule
